// File: rtl/cam_pkg.sv
// Shared types and default sizing for the NoC router CAM search engine.
package cam_pkg;

  localparam int CAM_DEPTH = 8;
  localparam int CAM_WIDTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef logic [CAM_WIDTH-1:0] tag_t;

endpackage

// File: rtl/cam_search_engine_if.sv
// Table-write, search-request and search-response signals of the CAM engine.
interface cam_search_engine_if
  import cam_pkg::*;
#(
  parameter  int DEPTH = CAM_DEPTH,
  parameter  int WIDTH = CAM_WIDTH,
  localparam int IDX_W = $clog2(DEPTH)
);

  logic             wr_en_i;
  logic [IDX_W-1:0] wr_idx_i;
  logic [WIDTH-1:0] wr_data_i;
  logic             inv_i;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [WIDTH-1:0] req_key_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic             rsp_hit_o;
  logic [IDX_W-1:0] rsp_idx_o;
  logic             busy_o;

  modport master (
    output wr_en_i, wr_idx_i, wr_data_i, inv_i,
    output req_valid_i, req_key_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_hit_o, rsp_idx_o, busy_o
  );

  modport slave (
    input  wr_en_i, wr_idx_i, wr_data_i, inv_i,
    input  req_valid_i, req_key_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_hit_o, rsp_idx_o, busy_o
  );

endinterface

// File: rtl/cam_search_engine_tag_bank.sv
// Per-entry tag and valid registers with one write/invalidate port and
// a combinational read port addressed by the scan index.
module cam_tag_bank
  import cam_pkg::*;
#(
  parameter  int DEPTH = CAM_DEPTH,
  parameter  int WIDTH = CAM_WIDTH,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             inv_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [WIDTH-1:0] rd_tag_o,
  output logic             rd_valid_o
);

  logic [WIDTH-1:0] tag_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  // Table update: a write also revalidates, so it takes priority over invalidate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
      end
      valid_q <= '0;
    end else if (wr_en_i) begin
      tag_q[wr_idx_i]   <= wr_data_i;
      valid_q[wr_idx_i] <= 1'b1;
    end else if (inv_i) begin
      valid_q[wr_idx_i] <= 1'b0;
    end
  end

  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];

endmodule

// File: rtl/cam_search_engine.sv
// Sequential CAM lookup: scans one entry per cycle and reports the lowest
// matching index over a valid/ready response handshake.
module cam_search_engine
  import cam_pkg::*;
#(
  parameter  int DEPTH = CAM_DEPTH,
  parameter  int WIDTH = CAM_WIDTH,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input logic               clk,
  input logic               rst,
  cam_search_engine_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             hit_q, hit_d;
  logic [WIDTH-1:0] rd_tag_s;
  logic             rd_valid_s;
  logic             match_s;

  cam_tag_bank #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_tag_bank (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (bus.wr_en_i),
    .wr_idx_i   (bus.wr_idx_i),
    .wr_data_i  (bus.wr_data_i),
    .inv_i      (bus.inv_i),
    .rd_idx_i   (scan_idx_q),
    .rd_tag_o   (rd_tag_s),
    .rd_valid_o (rd_valid_s)
  );

  // Compare sees the registered table, so a same-cycle write to this entry is not yet visible.
  assign match_s = rd_valid_s && (rd_tag_s == key_q);

  // Next-state logic for the scan FSM, the scan counter and the response registers.
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    scan_idx_d = scan_idx_q;
    idx_d      = idx_q;
    hit_d      = hit_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid_i) begin
          key_d      = bus.req_key_i;
          scan_idx_d = '0;
          state_d    = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (match_s) begin
          hit_d   = 1'b1;
          idx_d   = scan_idx_q;
          state_d = ST_RESP;
        end else if (scan_idx_q == IDX_W'(DEPTH - 1)) begin
          hit_d   = 1'b0;
          idx_d   = '0;
          state_d = ST_RESP;
        end else begin
          scan_idx_d = scan_idx_q + IDX_W'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and response registers; reset aborts any scan without a response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      key_q      <= '0;
      scan_idx_q <= '0;
      idx_q      <= '0;
      hit_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      scan_idx_q <= scan_idx_d;
      idx_q      <= idx_d;
      hit_q      <= hit_d;
    end
  end

  assign bus.req_ready_o = (state_q == ST_IDLE);
  assign bus.rsp_valid_o = (state_q == ST_RESP);
  assign bus.busy_o      = (state_q != ST_IDLE);
  assign bus.rsp_hit_o   = hit_q;
  assign bus.rsp_idx_o   = idx_q;

endmodule

// File: tb/tb_cam_search_engine.sv
// Self-checking bench for cam_search_engine: directed scenarios plus randomized
// searches checked against a table model that scores lowest-index matches.
module tb_cam_search_engine;
  import cam_pkg::*;

  localparam int DEPTH = 8;
  localparam int WIDTH = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [WIDTH-1:0] m_tag [DEPTH];
  bit               m_val [DEPTH];

  cam_search_engine_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  cam_search_engine #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_tag[i] = 3'd0;
      m_val[i] = 1'b0;
    end
  endtask

  // One clock: the model applies whatever write/invalidate the DUT samples at this edge.
  task automatic cycle();
    logic       we = bus.wr_en_i;
    logic       iv = bus.inv_i;
    logic [2:0] wi = bus.wr_idx_i;
    logic [2:0] wd = bus.wr_data_i;
    @(posedge clk);
    if (rst) begin
      if (we) begin
        m_tag[wi] = wd;
        m_val[wi] = 1'b1;
      end else if (iv) begin
        m_val[wi] = 1'b0;
      end
    end
    #1;
    bus.wr_en_i = 1'b0;
    bus.inv_i   = 1'b0;
  endtask

  task automatic write_entry(input logic [2:0] idx, input logic [2:0] data, input bit also_inv);
    bus.wr_en_i   = 1'b1;
    bus.inv_i     = also_inv;
    bus.wr_idx_i  = idx;
    bus.wr_data_i = data;
    cycle();
  endtask

  task automatic inv_entry(input logic [2:0] idx);
    bus.inv_i    = 1'b1;
    bus.wr_idx_i = idx;
    cycle();
  endtask

  // Drives one search; reports DUT observations and the model's expectation.
  // Entry k is compared in the k-th cycle after acceptance, against the table as it stood then.
  task automatic search(input logic [2:0] key, input int hold, input int wcyc,
                        input logic [2:0] widx, input logic [2:0] wdata,
                        input bit wen, input bit winv,
                        output logic o_hit, output logic [2:0] o_idx, output int o_lat,
                        output logic e_hit, output logic [2:0] e_idx, output int e_lat,
                        output int bad);
    bad = 0; e_hit = 1'b0; e_idx = 3'd0; o_lat = -1; o_hit = 1'b0; o_idx = 3'd0;
    bus.req_valid_i = 1'b1;
    bus.req_key_i   = key;
    bus.rsp_ready_i = (hold == 0);
    for (int c = 0; c < 40 && o_lat < 0; c++) begin
      if (c >= 1 && c <= DEPTH && !e_hit && m_val[c-1] && m_tag[c-1] == key) begin
        e_hit = 1'b1;
        e_idx = 3'(c - 1);
      end
      if (c == wcyc) begin
        bus.wr_en_i   = wen;
        bus.inv_i     = winv;
        bus.wr_idx_i  = widx;
        bus.wr_data_i = wdata;
      end
      if (c >= 1 && (bus.req_ready_o !== 1'b0 || bus.busy_o !== 1'b1)) bad++;
      cycle();
      if (c == 0) bus.req_valid_i = 1'b0;
      if (bus.rsp_valid_o === 1'b1) begin
        o_lat = c + 1;
        o_hit = bus.rsp_hit_o;
        o_idx = bus.rsp_idx_o;
      end
    end
    e_lat = e_hit ? int'(e_idx) + 2 : DEPTH + 1;
    if (o_lat >= 0) begin
      for (int h = 0; h < hold; h++) begin
        cycle();
        if (bus.rsp_valid_o !== 1'b1 || bus.rsp_hit_o !== o_hit ||
            bus.rsp_idx_o !== o_idx || bus.req_ready_o !== 1'b0) bad++;
      end
      bus.rsp_ready_i = 1'b1;
      cycle();
      if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1 || bus.busy_o !== 1'b0) bad++;
    end
  endtask

  task automatic test_reset();
    checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.req_ready_o); end
    checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.rsp_valid_o); end
    checks++; if (bus.rsp_hit_o !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b want 0", bus.rsp_hit_o); end
    checks++; if (bus.rsp_idx_o !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", bus.rsp_idx_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
  endtask

  task automatic test_empty_miss();
    logic h, eh; logic [2:0] ix, ei; int lat, el, bad;
    search(3'd3, 0, -1, 3'd0, 3'd0, 1'b0, 1'b0, h, ix, lat, eh, ei, el, bad);
    checks++; if (lat !== 9) begin errors++; $display("FAIL empty_latency: got %0d want 9", lat); end
    checks++; if (h !== 1'b0 || ix !== 3'd0) begin errors++; $display("FAIL empty_result: got hit=%b idx=%0d want 0/0", h, ix); end
    checks++; if (bad != 0) begin errors++; $display("FAIL empty_handshake: %0d violations want 0", bad); end
  endtask

  task automatic test_lowest_hit();
    logic h, eh; logic [2:0] ix, ei; int lat, el, bad;
    write_entry(3'd2, 3'd5, 1'b0);
    write_entry(3'd6, 3'd5, 1'b0);
    search(3'd5, 0, -1, 3'd0, 3'd0, 1'b0, 1'b0, h, ix, lat, eh, ei, el, bad);
    checks++; if (lat !== 4) begin errors++; $display("FAIL lowest_latency: got %0d want 4", lat); end
    checks++; if (h !== 1'b1 || ix !== 3'd2) begin errors++; $display("FAIL lowest_result: got hit=%b idx=%0d want 1/2", h, ix); end
  endtask

  task automatic test_backpressure();
    logic h, eh; logic [2:0] ix, ei; int lat, el, bad;
    write_entry(3'd7, 3'd1, 1'b0);
    search(3'd1, 5, -1, 3'd0, 3'd0, 1'b0, 1'b0, h, ix, lat, eh, ei, el, bad);
    checks++; if (lat !== 9 || h !== 1'b1 || ix !== 3'd7) begin errors++; $display("FAIL bp_result: got lat=%0d hit=%b idx=%0d want 9/1/7", lat, h, ix); end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d stability/ready violations want 0", bad); end
  endtask

  task automatic test_invalidate();
    logic h, eh; logic [2:0] ix, ei; int lat, el, bad;
    write_entry(3'd4, 3'd6, 1'b0);
    inv_entry(3'd4);
    search(3'd6, 0, -1, 3'd0, 3'd0, 1'b0, 1'b0, h, ix, lat, eh, ei, el, bad);
    checks++; if (h !== 1'b0 || ix !== 3'd0 || lat !== 9) begin errors++; $display("FAIL inv_miss: got hit=%b idx=%0d lat=%0d want 0/0/9", h, ix, lat); end
    write_entry(3'd4, 3'd6, 1'b1);
    search(3'd6, 0, -1, 3'd0, 3'd0, 1'b0, 1'b0, h, ix, lat, eh, ei, el, bad);
    checks++; if (h !== 1'b1 || ix !== 3'd4 || lat !== 6) begin errors++; $display("FAIL write_wins: got hit=%b idx=%0d lat=%0d want 1/4/6", h, ix, lat); end
  endtask

  task automatic test_write_during_scan();
    logic h, eh; logic [2:0] ix, ei; int lat, el, bad;
    for (int i = 0; i < DEPTH; i++) inv_entry(3'(i));
    search(3'd2, 0, 2, 3'd5, 3'd2, 1'b1, 1'b0, h, ix, lat, eh, ei, el, bad);
    checks++; if (h !== 1'b1 || ix !== 3'd5 || lat !== 7) begin errors++; $display("FAIL ahead_write: got hit=%b idx=%0d lat=%0d want 1/5/7", h, ix, lat); end
    inv_entry(3'd5);
    search(3'd2, 0, 3, 3'd0, 3'd2, 1'b1, 1'b0, h, ix, lat, eh, ei, el, bad);
    checks++; if (h !== 1'b0 || ix !== 3'd0 || lat !== 9) begin errors++; $display("FAIL passed_write: got hit=%b idx=%0d lat=%0d want 0/0/9", h, ix, lat); end
  endtask

  task automatic test_random();
    logic h, eh; logic [2:0] ix, ei; int lat, el, bad;
    for (int n = 0; n < 40; n++) begin
      for (int w = 0; w < 2; w++) begin
        if ($urandom_range(0, 2) == 0) inv_entry(3'($urandom_range(0, 7)));
        else write_entry(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end
      search(3'($urandom_range(0, 7)), $urandom_range(0, 2), $urandom_range(0, 9),
             3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             h, ix, lat, eh, ei, el, bad);
      checks++; if (h !== eh || ix !== ei) begin errors++; $display("FAIL rand_result[%0d]: got hit=%b idx=%0d want %b/%0d", n, h, ix, eh, ei); end
      checks++; if (lat !== el) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, lat, el); end
      checks++; if (bad != 0) begin errors++; $display("FAIL rand_handshake[%0d]: %0d violations want 0", n, bad); end
    end
  endtask

  task automatic test_reset_mid_scan();
    logic h, eh; logic [2:0] ix, ei; int lat, el, bad;
    write_entry(3'd3, 3'd4, 1'b0);
    bus.req_valid_i = 1'b1;
    bus.req_key_i   = 3'd4;
    cycle();
    bus.req_valid_i = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    checks++; if (bus.req_ready_o !== 1'b1 || bus.rsp_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      errors++; $display("FAIL abort_state: got ready=%b valid=%b busy=%b want 1/0/0", bus.req_ready_o, bus.rsp_valid_o, bus.busy_o);
    end
    model_clear();
    cycle();
    checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL abort_no_rsp: got valid=%b want 0", bus.rsp_valid_o); end
    rst = 1'b1;
    cycle();
    search(3'd4, 0, -1, 3'd0, 3'd0, 1'b0, 1'b0, h, ix, lat, eh, ei, el, bad);
    checks++; if (h !== 1'b0 || ix !== 3'd0 || lat !== 9) begin errors++; $display("FAIL table_cleared: got hit=%b idx=%0d lat=%0d want 0/0/9", h, ix, lat); end
  endtask

  initial begin
    bus.wr_en_i = 1'b0; bus.wr_idx_i = 3'd0; bus.wr_data_i = 3'd0; bus.inv_i = 1'b0;
    bus.req_valid_i = 1'b0; bus.req_key_i = 3'd0; bus.rsp_ready_i = 1'b1;
    model_clear();
    #12;
    test_reset();
    #10;
    rst = 1'b1;
    cycle();
    test_empty_miss();
    test_lowest_hit();
    test_backpressure();
    test_invalidate();
    test_write_during_scan();
    test_random();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
